// File: rtl/fpga_system_led_sequencer_if.sv
// Bus bundle for the LED sequencer: Avalon-MM CSR slave signals plus the
// write-only master port that drives the red-LED PIO s1 slave.
interface fpga_system_led_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        led_chipselect;
  logic        led_write_n;
  logic [1:0]  led_address;
  logic [31:0] led_writedata;

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, led_chipselect, led_write_n, led_address, led_writedata
  );

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, led_chipselect, led_write_n, led_address, led_writedata
  );
endinterface

// File: rtl/fpga_system_led_sequencer.sv
// Autonomous red-LED sequencer: CPU-configured CSR block that pushes one
// single-cycle PIO write per step in static, rotate, bounce or table mode.
module fpga_system_led_sequencer #(
  parameter int          LED_WIDTH    = 18,
  parameter int          TBL_DEPTH    = 16,
  parameter logic [31:0] PERIOD_RESET = 32'd50000000
) (
  input  logic                              clk,
  input  logic                              reset_n,
  fpga_system_led_sequencer_if.slave        bus
);

  localparam int IW = $clog2(TBL_DEPTH);
  localparam int LW = IW + 1;

  typedef enum logic [2:0] {S_IDLE, S_PUSH, S_WAIT, S_STEP, S_HOLD} state_t;
  typedef enum logic [1:0] {M_STATIC, M_ROTATE, M_BOUNCE, M_TABLE} mode_t;

  state_t               state, next_state;
  logic                 enable, oneshot;
  mode_t                mode;
  logic [31:0]          period, cnt, period_eff;
  logic [LED_WIDTH-1:0] pattern, cur, step_val, start_val;
  logic                 running, done, dir_down, step_dir_down;
  logic [IW-1:0]        tbl_idx, ptr, ptr_next;
  logic [LW-1:0]        tbl_len, len_wr_val;
  logic [LED_WIDTH-1:0] table_mem [TBL_DEPTH];

  logic wr, wr_ctrl, wr_period, wr_pattern, wr_status;
  logic wr_tbl_idx, wr_tbl_dat, wr_tbl_len;
  logic start, stop, last_entry, oneshot_end;

  assign wr         = bus.chipselect & ~bus.write_n;
  assign wr_ctrl    = wr & (bus.address == 3'd0);
  assign wr_period  = wr & (bus.address == 3'd1);
  assign wr_pattern = wr & (bus.address == 3'd2);
  assign wr_status  = wr & (bus.address == 3'd3);
  assign wr_tbl_idx = wr & (bus.address == 3'd4);
  assign wr_tbl_dat = wr & (bus.address == 3'd5);
  assign wr_tbl_len = wr & (bus.address == 3'd6);

  assign start = wr_ctrl &  bus.writedata[0];
  assign stop  = wr_ctrl & ~bus.writedata[0];

  assign period_eff  = (period < 32'd2) ? 32'd2 : period;
  assign last_entry  = ({1'b0, ptr} == tbl_len - LW'(1));
  // A shortened table (LEN below ptr) wraps to entry 0 on the next step.
  assign ptr_next    = ({1'b0, ptr} >= tbl_len - LW'(1)) ? '0 : ptr + IW'(1);
  assign oneshot_end = (state == S_PUSH) && (mode == M_TABLE) && oneshot && last_entry;
  assign start_val   = (mode_t'(bus.writedata[2:1]) == M_TABLE) ? table_mem[0] : pattern;

  always_comb begin
    if (bus.writedata == 32'd0)                 len_wr_val = LW'(1);
    else if (bus.writedata > 32'(TBL_DEPTH))    len_wr_val = LW'(TBL_DEPTH);
    else                                        len_wr_val = bus.writedata[LW-1:0];
  end

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    step_val      = cur;
    step_dir_down = dir_down;
    case (mode)
      M_ROTATE: step_val = {cur[LED_WIDTH-2:0], cur[LED_WIDTH-1]};
      M_BOUNCE: begin
        if (!dir_down) begin
          step_val = cur << 1;
          if (step_val[LED_WIDTH-1]) step_dir_down = 1'b1;
        end else begin
          step_val = cur >> 1;
          if (step_val[0]) step_dir_down = 1'b0;
        end
      end
      M_TABLE:  step_val = table_mem[ptr_next];
      default:  ;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: ;
      S_PUSH: begin
        if (mode == M_STATIC)            next_state = S_HOLD;
        else if (oneshot_end)            next_state = S_IDLE;
        else if (period_eff == 32'd2)    next_state = S_STEP;
        else                             next_state = S_WAIT;
      end
      S_WAIT: if (cnt <= 32'd1) next_state = S_STEP;
      S_STEP: next_state = S_PUSH;
      S_HOLD: if (wr_pattern) next_state = S_PUSH;
      default: next_state = S_IDLE;
    endcase
    // CPU control writes override whatever the sequence was doing.
    if (start)     next_state = S_PUSH;
    else if (stop) next_state = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable   <= 1'b0;
      mode     <= M_STATIC;
      oneshot  <= 1'b0;
      period   <= PERIOD_RESET;
      pattern  <= '0;
      tbl_idx  <= '0;
      tbl_len  <= LW'(1);
      done     <= 1'b0;
      running  <= 1'b0;
      cur      <= '0;
      ptr      <= '0;
      dir_down <= 1'b0;
      cnt      <= '0;
    end else begin
      if (wr_ctrl) begin
        enable  <= bus.writedata[0];
        mode    <= mode_t'(bus.writedata[2:1]);
        oneshot <= bus.writedata[3];
      end else if (oneshot_end) begin
        enable  <= 1'b0;
      end

      if (wr_period)  period  <= bus.writedata;
      if (wr_pattern) pattern <= bus.writedata[LED_WIDTH-1:0];
      if (wr_tbl_len) tbl_len <= len_wr_val;

      if (wr_tbl_dat)      tbl_idx <= tbl_idx + IW'(1);
      else if (wr_tbl_idx) tbl_idx <= bus.writedata[IW-1:0];

      if (oneshot_end)                        done <= 1'b1;
      else if (wr_status && bus.writedata[1]) done <= 1'b0;

      if (wr_ctrl)          running <= bus.writedata[0];
      else if (oneshot_end) running <= 1'b0;

      if (start) begin
        cur      <= start_val;
        ptr      <= '0;
        dir_down <= 1'b0;
      end else if (state == S_HOLD && wr_pattern) begin
        cur      <= bus.writedata[LED_WIDTH-1:0];
      end else if (state == S_STEP && !stop) begin
        cur      <= step_val;
        dir_down <= step_dir_down;
        if (mode == M_TABLE) ptr <= ptr_next;
      end

      // PUSH plus STEP account for two clocks of every step, WAIT covers the rest.
      if (state == S_PUSH)      cnt <= period_eff - 32'd2;
      else if (state == S_WAIT) cnt <= cnt - 32'd1;
    end
  end

  // NOTE: the table is a small register file, reset so that unwritten entries read as zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TBL_DEPTH; i++) table_mem[i] <= '0;
    end else if (wr_tbl_dat) begin
      table_mem[tbl_idx] <= bus.writedata[LED_WIDTH-1:0];
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      3'd0:    bus.readdata = {28'd0, oneshot, mode, enable};
      3'd1:    bus.readdata = period;
      3'd2:    bus.readdata = 32'(pattern);
      3'd3:    bus.readdata = {30'd0, done, running};
      3'd4:    bus.readdata = 32'(tbl_idx);
      3'd6:    bus.readdata = 32'(tbl_len);
      3'd7:    bus.readdata = 32'(cur);
      default: bus.readdata = '0;
    endcase
  end

  assign bus.led_chipselect = (state == S_PUSH);
  assign bus.led_write_n    = (state != S_PUSH);
  assign bus.led_address    = 2'd0;
  assign bus.led_writedata  = (state == S_PUSH) ? 32'(cur) : 32'd0;

endmodule

// File: tb/tb_fpga_system_led_sequencer.sv
// Self-checking bench for the LED sequencer: directed scenarios plus randomized
// rotate/bounce/table runs compared against a strobe-list reference model.
module tb_fpga_system_led_sequencer;
  localparam logic [31:0] MASK         = 32'h0003_FFFF;
  localparam logic [31:0] PERIOD_RESET = 32'd50000000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fpga_system_led_sequencer_if bus();

  fpga_system_led_sequencer #(
    .LED_WIDTH(18), .TBL_DEPTH(16), .PERIOD_RESET(PERIOD_RESET)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log, sampled mid-cycle.
  logic [31:0] sq_data[$];
  int          sq_cyc[$];
  logic [1:0]  sq_addr[$];
  always @(negedge clk) begin
    if (bus.led_chipselect && !bus.led_write_n) begin
      sq_data.push_back(bus.led_writedata);
      sq_cyc.push_back(cyc);
      sq_addr.push_back(bus.led_address);
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic clear_strobes();
    sq_data.delete(); sq_cyc.delete(); sq_addr.delete();
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    #1 d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_strobes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sq_data.size() >= n) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  // Reference: list of patterns pushed by modes 1/2 from a start value.
  task automatic build_walk(input int mode, input logic [31:0] start, input int n);
    logic [31:0] v;
    bit down;
    v = start & MASK; down = 1'b0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(v);
      if (mode == 1) begin
        v = ((v << 1) | (v >> 17)) & MASK;
      end else if (!down) begin
        v = (v << 1) & MASK;
        if (v[17]) down = 1'b1;
      end else begin
        v = v >> 1;
        if (v[0]) down = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] exp_regs [8];
    exp_regs = '{32'd0, PERIOD_RESET, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0};
    n_cmp++;
    if (bus.led_chipselect !== 1'b0 || bus.led_write_n !== 1'b1 || bus.led_writedata !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: cs=%b wn=%b wd=%h, want cs=0 wn=1 wd=0",
               bus.led_chipselect, bus.led_write_n, bus.led_writedata);
    end
    for (int a = 0; a < 8; a++) begin
      csr_read(3'(a), rd);
      n_cmp++;
      if (rd !== exp_regs[a]) begin
        n_err++;
        $display("FAIL reset_csr%0d: got %h want %h", a, rd, exp_regs[a]);
      end
    end
    wait_cycles(1);
  endtask

  task automatic test_static();
    int t0;
    logic [31:0] rd;
    csr_write(3'd2, 32'h0002_A5A5);
    csr_write(3'd0, 32'h1);
    t0 = cyc; clear_strobes();
    wait_cycles(20);
    n_cmp++;
    if (sq_data.size() !== 1 || sq_data[0] !== 32'h0002_A5A5 || sq_cyc[0] !== t0 || sq_addr[0] !== 2'd0) begin
      n_err++;
      $display("FAIL static_first: count=%0d data=%h cyc=%0d, want 1 strobe 0002a5a5 at cyc %0d",
               sq_data.size(), sq_data.size() > 0 ? sq_data[0] : 32'hx, sq_cyc.size() > 0 ? sq_cyc[0] : -1, t0);
    end
    csr_write(3'd2, 32'h1);
    t0 = cyc; clear_strobes();
    wait_cycles(20);
    n_cmp++;
    if (sq_data.size() !== 1 || sq_data[0] !== 32'h1 || sq_cyc[0] !== t0) begin
      n_err++;
      $display("FAIL static_repattern: count=%0d data=%h, want 1 strobe 00000001 at cyc %0d",
               sq_data.size(), sq_data.size() > 0 ? sq_data[0] : 32'hx, t0);
    end
    csr_read(3'd7, rd);
    n_cmp++;
    if (rd !== 32'h1) begin n_err++; $display("FAIL static_current: got %h want 00000001", rd); end
    wait_cycles(1);
  endtask

  task automatic run_walk(input string name, input int mode, input logic [31:0] pat,
                          input logic [31:0] per, input int n);
    int t0, peff;
    bit ok;
    peff = (per < 2) ? 2 : int'(per);
    csr_write(3'd2, pat);
    csr_write(3'd1, per);
    csr_write(3'd0, 32'(mode << 1) | 32'h1);
    t0 = cyc; clear_strobes();
    build_walk(mode, pat, n);
    wait_strobes(n, n * peff + 20, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d strobes want %0d", name, sq_data.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        n_cmp++;
        if (sq_data[i] !== exp_q[i] || sq_cyc[i] !== t0 + i * peff) begin
          n_err++;
          $display("FAIL %s_step%0d: data=%h cyc=%0d want data=%h cyc=%0d",
                   name, i, sq_data[i], sq_cyc[i], exp_q[i], t0 + i * peff);
        end
      end
    end
  endtask

  task automatic test_rotate();
    run_walk("rotate", 1, 32'h0002_0001, 32'd4, 3);
  endtask

  task automatic test_bounce();
    run_walk("bounce", 2, 32'h0001_0000, 32'd2, 4);
    run_walk("bounce_p0", 2, 32'h0001_0000, 32'd0, 4);
  endtask

  task automatic test_random_walk();
    for (int i = 0; i < 8; i++) begin
      int mode;
      logic [31:0] pat, per;
      mode = 1 + int'($urandom_range(0, 1));
      pat  = (i == 0) ? 32'd0 : ($urandom & MASK);
      per  = 32'($urandom_range(0, 7));
      run_walk("random_walk", mode, pat, per, 6);
    end
  endtask

  task automatic test_table_oneshot();
    int t0;
    logic [31:0] rd;
    csr_write(3'd4, 32'd0);
    csr_write(3'd5, 32'h1);
    csr_write(3'd5, 32'h2);
    csr_write(3'd5, 32'h3);
    csr_read(3'd4, rd);
    n_cmp++;
    if (rd !== 32'd3) begin n_err++; $display("FAIL tbl_idx_incr: got %h want 3", rd); end
    csr_write(3'd6, 32'd3);
    csr_write(3'd1, 32'd3);
    csr_write(3'd0, 32'hF);
    t0 = cyc; clear_strobes();
    wait_cycles(30);
    n_cmp++;
    if (sq_data.size() !== 3) begin
      n_err++;
      $display("FAIL oneshot_count: got %0d strobes want 3", sq_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (sq_data[i] !== 32'(i + 1) || sq_cyc[i] !== t0 + 3 * i) begin
          n_err++;
          $display("FAIL oneshot_entry%0d: data=%h cyc=%0d want data=%h cyc=%0d",
                   i, sq_data[i], sq_cyc[i], 32'(i + 1), t0 + 3 * i);
        end
      end
    end
    csr_read(3'd3, rd);
    n_cmp++;
    if (rd !== 32'h2) begin n_err++; $display("FAIL oneshot_status: got %h want 00000002", rd); end
    csr_read(3'd0, rd);
    n_cmp++;
    if (rd !== 32'hE) begin n_err++; $display("FAIL oneshot_ctrl: got %h want 0000000e", rd); end
    wait_cycles(1);
    csr_write(3'd3, 32'h2);
    csr_read(3'd3, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL done_w1c: got %h want 00000000", rd); end
    wait_cycles(1);
  endtask

  task automatic test_table_random();
    int lens [3];
    lens = '{0, 2 + int'($urandom_range(0, 14)), 20};
    for (int it = 0; it < 3; it++) begin
      logic [31:0] tbl [16];
      logic [31:0] rd;
      int leff, n, t0;
      bit ok;
      csr_write(3'd4, 32'd0);
      for (int e = 0; e < 16; e++) begin
        tbl[e] = $urandom;
        csr_write(3'd5, tbl[e]);
      end
      csr_read(3'd4, rd);
      n_cmp++;
      if (rd !== 32'd0) begin n_err++; $display("FAIL tbl_idx_wrap: got %h want 0", rd); end
      leff = (lens[it] == 0) ? 1 : (lens[it] > 16 ? 16 : lens[it]);
      csr_write(3'd6, 32'(lens[it]));
      csr_read(3'd6, rd);
      n_cmp++;
      if (rd !== 32'(leff)) begin n_err++; $display("FAIL tbl_len_clamp: got %h want %h", rd, 32'(leff)); end
      csr_write(3'd1, 32'd2);
      csr_write(3'd0, 32'h7);
      t0 = cyc; clear_strobes();
      n = 2 * leff + 1;
      wait_strobes(n, 2 * n + 20, ok);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL table_timeout: got %0d strobes want %0d", sq_data.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          n_cmp++;
          if (sq_data[i] !== (tbl[i % leff] & MASK) || sq_cyc[i] !== t0 + 2 * i) begin
            n_err++;
            $display("FAIL table_step%0d: data=%h cyc=%0d want data=%h cyc=%0d",
                     i, sq_data[i], sq_cyc[i], tbl[i % leff] & MASK, t0 + 2 * i);
          end
        end
      end
    end
  endtask

  task automatic test_disable();
    bit ok;
    logic [31:0] rd;
    csr_write(3'd2, 32'h1);
    csr_write(3'd1, 32'd5);
    csr_write(3'd0, 32'h3);
    clear_strobes();
    wait_strobes(2, 30, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL disable_timeout: got %0d strobes want 2", sq_data.size()); end
    csr_write(3'd0, 32'h2);
    clear_strobes();
    wait_cycles(50);
    n_cmp++;
    if (sq_data.size() !== 0) begin n_err++; $display("FAIL disable_quiet: got %0d strobes want 0", sq_data.size()); end
    csr_read(3'd7, rd);
    n_cmp++;
    if (rd !== 32'h2) begin n_err++; $display("FAIL disable_current: got %h want 00000002", rd); end
    csr_read(3'd3, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL disable_status: got %h want 00000000", rd); end
    wait_cycles(1);
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [31:0] rd;
    csr_write(3'd2, 32'h3);
    csr_write(3'd1, 32'd6);
    csr_write(3'd0, 32'h3);
    clear_strobes();
    wait_strobes(1, 20, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL reset_mid_timeout: no strobe seen"); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.led_chipselect !== 1'b0 || bus.led_write_n !== 1'b1 || bus.led_writedata !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: cs=%b wn=%b wd=%h, want cs=0 wn=1 wd=0",
               bus.led_chipselect, bus.led_write_n, bus.led_writedata);
    end
    csr_read(3'd7, rd);
    n_cmp++;
    if (rd !== 32'd0) begin n_err++; $display("FAIL reset_mid_current: got %h want 0", rd); end
    csr_read(3'd3, rd);
    n_cmp++;
    if (rd !== 32'd0) begin n_err++; $display("FAIL reset_mid_status: got %h want 0", rd); end
    csr_read(3'd1, rd);
    n_cmp++;
    if (rd !== PERIOD_RESET) begin n_err++; $display("FAIL reset_mid_period: got %h want %h", rd, PERIOD_RESET); end
    @(posedge clk); #1 reset_n = 1'b1;
    clear_strobes();
    wait_cycles(20);
    n_cmp++;
    if (sq_data.size() !== 0) begin n_err++; $display("FAIL reset_mid_quiet: got %0d strobes want 0", sq_data.size()); end
  endtask

  initial begin
    bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    wait_cycles(1);
    test_reset();
    test_static();
    test_rotate();
    test_bounce();
    test_random_walk();
    test_table_oneshot();
    test_table_random();
    test_disable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1);
  end

endmodule
